// File: rtl/msg_stream_sched.sv
// Round-robin scheduler that streams one of four fixed ASCII messages onto a shared
// valid/ready character port, with a programmable idle gap between messages.
module msg_stream_sched #(
  parameter int GAP_CYCLES = 2,
  parameter int CHAR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic              abort,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_last,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic              aborted,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // With no gap configured, a finished or aborted message returns straight to arbitration.
  localparam state_t END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t            state, state_next;
  logic [1:0]        ptr, ptr_next;
  logic [1:0]        winner, winner_next;
  logic [3:0]        idx, idx_next;
  logic [GW-1:0]     gap_cnt, gap_cnt_next;
  logic [CHAR_W-1:0] char_out_next;
  logic              valid_next, last_next, aborted_next;
  logic [3:0]        gnt_next, ack_next;
  logic [1:0]        pick, cand;
  logic              pick_found;
  logic              transfer, last_beat, gap_done;

  function automatic logic [7:0] rom_char(input logic [1:0] m, input logic [3:0] i);
    logic [7:0] c;
    c = 8'h00;
    case (m)
      2'd0: case (i)
        4'd0: c = "G"; 4'd1: c = "u"; 4'd2: c = "a"; 4'd3: c = "t"; 4'd4: c = "e";
        4'd5: c = "m"; 4'd6: c = "a"; 4'd7: c = "l"; 4'd8: c = "a";
        default: c = 8'h00;
      endcase
      2'd1: case (i)
        4'd0: c = "Q"; 4'd1: c = "u"; 4'd2: c = "e"; 4'd3: c = "t"; 4'd4: c = "z";
        4'd5: c = "a"; 4'd6: c = "l";
        default: c = 8'h00;
      endcase
      2'd2: case (i)
        4'd0: c = "Z"; 4'd1: c = "a"; 4'd2: c = "c"; 4'd3: c = "a"; 4'd4: c = "p";
        4'd5: c = "a";
        default: c = 8'h00;
      endcase
      default: case (i)
        4'd0: c = "S"; 4'd1: c = "o"; 4'd2: c = "y";
        default: c = 8'h00;
      endcase
    endcase
    return c;
  endfunction

  function automatic logic [3:0] msg_len(input logic [1:0] m);
    logic [3:0] n;
    case (m)
      2'd0:    n = 4'd9;
      2'd1:    n = 4'd7;
      2'd2:    n = 4'd6;
      default: n = 4'd3;
    endcase
    return n;
  endfunction

  assign transfer  = char_valid & char_ready;
  assign last_beat = (idx == msg_len(winner) - 4'd1);
  assign gap_done  = (gap_cnt == GW'(GAP_CYCLES - 1));

  // Scan upward from the requester after the last winner, wrapping at 4.
  always_comb begin
    pick       = ptr;
    cand       = ptr;
    pick_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!pick_found && req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 2'd3;
      winner     <= 2'd0;
      idx        <= 4'd0;
      gap_cnt    <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      gnt        <= 4'b0;
      ack        <= 4'b0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      winner     <= winner_next;
      idx        <= idx_next;
      gap_cnt    <= gap_cnt_next;
      char_out   <= char_out_next;
      char_valid <= valid_next;
      char_last  <= last_next;
      gnt        <= gnt_next;
      ack        <= ack_next;
      aborted    <= aborted_next;
      busy       <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = SEND;
      SEND:    if (abort || (transfer && last_beat)) state_next = END_STATE;
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Abort wins over a same-cycle transfer, so the beat on the port is simply dropped.
  always_comb begin
    ptr_next      = ptr;
    winner_next   = winner;
    idx_next      = idx;
    gap_cnt_next  = gap_cnt;
    char_out_next = char_out;
    valid_next    = char_valid;
    last_next     = char_last;
    gnt_next      = gnt;
    ack_next      = 4'b0;
    aborted_next  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          ptr_next      = pick;
          winner_next   = pick;
          idx_next      = 4'd0;
          char_out_next = CHAR_W'(rom_char(pick, 4'd0));
          valid_next    = 1'b1;
          last_next     = (msg_len(pick) == 4'd1);
          gnt_next      = 4'b0001 << pick;
        end
      end
      SEND: begin
        if (abort) begin
          valid_next   = 1'b0;
          last_next    = 1'b0;
          gnt_next     = 4'b0;
          aborted_next = 1'b1;
          gap_cnt_next = '0;
        end else if (transfer) begin
          if (last_beat) begin
            valid_next   = 1'b0;
            last_next    = 1'b0;
            gnt_next     = 4'b0;
            ack_next     = gnt;
            gap_cnt_next = '0;
          end else begin
            idx_next      = idx + 4'd1;
            char_out_next = CHAR_W'(rom_char(winner, idx + 4'd1));
            last_next     = (idx + 4'd2 == msg_len(winner));
          end
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt + 1'b1;
      end
      default: begin
        valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_msg_stream_sched.sv
// Self-checking bench for msg_stream_sched: directed scenarios plus randomized traffic
// compared against a message-level round-robin model.
module tb_msg_stream_sched;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0;
  logic       abort = 1'b0;
  logic       char_ready = 1'b0;
  logic [7:0] char_out;
  logic       char_valid, char_last, aborted, busy;
  logic [3:0] gnt, ack;

  logic [3:0] req_g0 = 4'b0;
  logic       abort_g0 = 1'b0;
  logic       ready_g0 = 1'b0;
  logic [7:0] char_g0;
  logic       valid_g0, last_g0, aborted_g0, busy_g0;
  logic [3:0] gnt_g0, ack_g0;

  int    total = 0;
  int    bad = 0;
  int    model_ptr = 3;
  string msgs [4];

  always #5 clk = ~clk;

  msg_stream_sched #(.GAP_CYCLES(GAP), .CHAR_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .abort(abort),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .char_last(char_last), .gnt(gnt), .ack(ack), .aborted(aborted), .busy(busy)
  );

  msg_stream_sched #(.GAP_CYCLES(0), .CHAR_W(8)) dut_g0 (
    .clk(clk), .reset(reset), .req(req_g0), .abort(abort_g0),
    .char_out(char_g0), .char_valid(valid_g0), .char_ready(ready_g0),
    .char_last(last_g0), .gnt(gnt_g0), .ack(ack_g0), .aborted(aborted_g0), .busy(busy_g0)
  );

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[2'((p + k) % 4)]) return (p + k) % 4;
    return -1;
  endfunction

  // Drives one full grant from IDLE through the gap; called at a negedge with the DUT idle.
  task automatic deliver_msg(input logic [3:0] r, input int rmode, input int abort_at,
                             output int cycles, output int accepted, output logic [3:0] first_gnt);
    int    w, cyc, k, pos, g;
    bit    done;
    string m;
    w = rr_pick(model_ptr, r);
    m = msgs[w];
    req = r;
    abort = 1'b0;
    char_ready = 1'b0;
    cycles = 0;
    accepted = 0;
    first_gnt = 4'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (char_valid !== 1'b1 && cyc < 20);
    total++;
    if (cyc != 1) begin
      bad++;
      $display("[TB] FAIL latency: got %0d cycles to first valid, want 1", cyc);
    end
    if (char_valid !== 1'b1) return;
    first_gnt = gnt;
    total++;
    if (gnt !== (4'b1 << w)) begin
      bad++;
      $display("[TB] FAIL grant: got %b, want %b", gnt, 4'b1 << w);
    end
    k = 0;
    pos = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      if (k > 0) @(negedge clk);
      case (rmode)
        0:       char_ready = 1'b1;
        1:       char_ready = (k % 2 == 0);
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
      if (rmode == 2) req = 4'($urandom_range(0, 15));
      abort = (pos == abort_at);
      total++;
      if (char_valid !== 1'b1 || gnt !== (4'b1 << w) || char_out !== m[pos] ||
          char_last !== (pos == m.len() - 1)) begin
        bad++;
        $display("[TB] FAIL beat %0d of msg%0d: got valid=%b char=%h last=%b gnt=%b, want valid=1 char=%h last=%b gnt=%b",
                 pos, w, char_valid, char_out, char_last, gnt, m[pos], pos == m.len() - 1, 4'b1 << w);
      end
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        req = 4'b0;
        total++;
        if (aborted !== 1'b1 || ack !== 4'b0 || char_valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL abort: got aborted=%b ack=%b valid=%b gnt=%b busy=%b, want 1 0000 0 0000 1",
                   aborted, ack, char_valid, gnt, busy);
        end
        done = 1'b1;
      end else if (char_ready) begin
        pos++;
        if (pos == m.len()) begin
          @(negedge clk);
          req = 4'b0;
          total++;
          if (ack !== (4'b1 << w) || aborted !== 1'b0 || char_valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ack: got ack=%b aborted=%b valid=%b gnt=%b busy=%b, want ack=%b 0 0 0000 1",
                     ack, aborted, char_valid, gnt, busy, 4'b1 << w);
          end
          done = 1'b1;
        end
      end
      k++;
    end
    abort = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL msg timeout: got %0d of %0d chars, want all", pos, m.len());
    end
    cycles = k;
    accepted = pos;
    model_ptr = w;
    g = 0;
    while (busy === 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g != GAP) begin
      bad++;
      $display("[TB] FAIL gap: got busy for %0d cycles after ack, want %0d", g, GAP);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (char_valid !== 1'b0 || char_out !== 8'h00 || char_last !== 1'b0 || gnt !== 4'b0 ||
        ack !== 4'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset held: got valid=%b char=%h last=%b gnt=%b ack=%b aborted=%b busy=%b, want all 0",
               char_valid, char_out, char_last, gnt, ack, aborted, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (char_valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || valid_g0 !== 1'b0 || busy_g0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset idle: got valid=%b gnt=%b busy=%b g0valid=%b g0busy=%b, want all 0",
               char_valid, gnt, busy, valid_g0, busy_g0);
    end
    model_ptr = 3;
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5];
    int         cycles, acc;
    logic [3:0] g;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      deliver_msg(4'b1111, 0, -1, cycles, acc, g);
      total++;
      if (g !== order[i]) begin
        bad++;
        $display("[TB] FAIL rr order %0d: got gnt=%b, want %b", i, g, order[i]);
      end
    end
  endtask

  task automatic test_single();
    int         cycles, acc;
    logic [3:0] g;
    deliver_msg(4'b0001, 0, -1, cycles, acc, g);
    total++;
    if (cycles != 9 || acc != 9 || g !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL single: got cycles=%0d chars=%0d gnt=%b, want 9 9 0001", cycles, acc, g);
    end
  endtask

  task automatic test_backpressure();
    int         cycles, acc;
    logic [3:0] g;
    deliver_msg(4'b0010, 1, -1, cycles, acc, g);
    total++;
    if (cycles != 13 || acc != 7 || g !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL backpressure: got cycles=%0d chars=%0d gnt=%b, want 13 7 0010", cycles, acc, g);
    end
  endtask

  task automatic test_abort();
    int         cycles, acc;
    logic [3:0] g;
    deliver_msg(4'b0100, 0, 2, cycles, acc, g);
    total++;
    if (acc != 2 || g !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL abort count: got chars=%0d gnt=%b, want 2 0100", acc, g);
    end
  endtask

  task automatic test_gap0();
    int    cyc, ph;
    string s;
    s = "Soy";
    req_g0 = 4'b1000;
    ready_g0 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (valid_g0 !== 1'b1 && cyc < 20);
    total++;
    if (cyc != 1) begin
      bad++;
      $display("[TB] FAIL gap0 latency: got %0d cycles, want 1", cyc);
    end
    for (int c = 0; c < 16; c++) begin
      ph = c % 4;
      if (c > 0) @(negedge clk);
      if (c == 15) req_g0 = 4'b0;
      total++;
      if (ph < 3) begin
        if (valid_g0 !== 1'b1 || char_g0 !== s[ph] || last_g0 !== (ph == 2) || gnt_g0 !== 4'b1000) begin
          bad++;
          $display("[TB] FAIL gap0 beat c=%0d: got valid=%b char=%h last=%b gnt=%b, want 1 %h %b 1000",
                   c, valid_g0, char_g0, last_g0, gnt_g0, s[ph], ph == 2);
        end
      end else begin
        if (valid_g0 !== 1'b0 || ack_g0 !== 4'b1000 || busy_g0 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL gap0 ack c=%0d: got valid=%b ack=%b busy=%b, want 0 1000 0",
                   c, valid_g0, ack_g0, busy_g0);
        end
      end
    end
    ready_g0 = 1'b0;
  endtask

  task automatic test_random();
    int         cycles, acc, w, ab, want;
    logic [3:0] r, g;
    for (int n = 0; n < 25; n++) begin
      r = 4'($urandom_range(1, 15));
      w = rr_pick(model_ptr, r);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, msgs[w].len() - 1)) : -1;
      deliver_msg(r, 2, ab, cycles, acc, g);
      want = (ab < 0) ? msgs[w].len() : ab;
      total++;
      if (acc != want) begin
        bad++;
        $display("[TB] FAIL random %0d: got %0d chars of msg%0d, want %0d", n, acc, w, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    int         cyc, cycles, acc;
    logic [3:0] g;
    req = 4'b0001;
    char_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (char_valid !== 1'b1 && cyc < 20);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (char_valid !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || char_last !== 1'b0 || char_out !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset mid: got valid=%b gnt=%b busy=%b last=%b char=%h, want all 0",
               char_valid, gnt, busy, char_last, char_out);
    end
    req = 4'b0011;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 3;
    total++;
    if (ack !== 4'b0 || aborted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset pulse: got ack=%b aborted=%b, want 0000 0", ack, aborted);
    end
    deliver_msg(4'b0011, 0, -1, cycles, acc, g);
    total++;
    if (g !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL reset prio: got gnt=%b, want 0001", g);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 3;
    deliver_msg(4'b0010, 0, -1, cycles, acc, g);
    total++;
    if (g !== 4'b0010 || acc != 7) begin
      bad++;
      $display("[TB] FAIL reset lone: got gnt=%b chars=%0d, want 0010 7", g, acc);
    end
  endtask

  initial begin
    msgs[0] = "Guatemala";
    msgs[1] = "Quetzal";
    msgs[2] = "Zacapa";
    msgs[3] = "Soy";
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_abort();
    test_gap0();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
